id_stage: RTL

Instruction-decode stage of the 5-stage MIPS pipeline. It holds the IF/ID latch, decodes one instruction per cycle, and drives the register-file read ports (enable plus address) combinationally. It resolves RAW hazards by forwarding from EX/MEM or by stalling, and registers the decoded operation into the ID/EX pipeline register consumed by the EX stage.

---
 rtl/id_stage.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, decode, register-file read, hazard resolution and
// the ID/EX pipeline register. Define FORWARDING_EN to bypass EX/MEM results instead of stalling.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        id_stall,
  output logic        rf_reA,
  output logic [4:0]  rf_addrA,
  output logic        rf_reB,
  output logic [4:0]  rf_addrB,
  input  logic [31:0] rf_dataA,
  input  logic [31:0] rf_dataB,
  input  logic [31:0] ex_result_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [3:0]  ex_aluop,
  output logic [31:0] ex_opa,
  output logic [31:0] ex_opb,
  output logic        ex_wreg,
  output logic [4:0]  ex_waddr,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic [31:0] ex_store_data
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAddu = 4'd1;
  localparam logic [3:0] AluSubu = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluNor  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSrl  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;

  typedef enum logic [1:0] {SelARs, SelARt, SelAZero} sel_a_e;
  typedef enum logic [2:0] {SelBRt, SelBSa, SelBSext, SelBZext, SelBLui, SelBZero} sel_b_e;

  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  assign op    = id_inst_q[31:26];
  assign rs    = id_inst_q[25:21];
  assign rt    = id_inst_q[20:16];
  assign rd    = id_inst_q[15:11];
  assign sa    = id_inst_q[10:6];
  assign funct = id_inst_q[5:0];
  assign imm   = id_inst_q[15:0];

  logic       re_a, re_b, dec_wreg, dec_load, dec_store;
  logic [3:0] alu;
  logic [4:0] dec_waddr;
  sel_a_e     sel_a;
  sel_b_e     sel_b;

  always_comb begin
    re_a      = 1'b0;
    re_b      = 1'b0;
    alu       = AluNop;
    dec_wreg  = 1'b0;
    dec_waddr = 5'd0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    sel_a     = SelAZero;
    sel_b     = SelBZero;
    if (id_valid_q) begin
      case (op)
        OpSpecial: begin
          unique case (funct)
            FnAddu:  alu = AluAddu;
            FnSubu:  alu = AluSubu;
            FnAnd:   alu = AluAnd;
            FnOr:    alu = AluOr;
            FnXor:   alu = AluXor;
            FnNor:   alu = AluNor;
            FnSlt:   alu = AluSlt;
            FnSll:   alu = AluSll;
            FnSrl:   alu = AluSrl;
            FnSra:   alu = AluSra;
            default: alu = AluNop;
          endcase
          if (alu >= AluSll) begin
            // Shifts take the shifted value from rt and the amount from the sa field.
            re_b      = 1'b1;
            sel_a     = SelARt;
            sel_b     = SelBSa;
            dec_wreg  = 1'b1;
            dec_waddr = rd;
          end else if (alu != AluNop) begin
            re_a      = 1'b1;
            re_b      = 1'b1;
            sel_a     = SelARs;
            sel_b     = SelBRt;
            dec_wreg  = 1'b1;
            dec_waddr = rd;
          end
        end
        OpAddiu, OpAndi, OpOri, OpXori: begin
          unique case (op)
            OpAddiu: alu = AluAddu;
            OpAndi:  alu = AluAnd;
            OpOri:   alu = AluOr;
            default: alu = AluXor;
          endcase
          re_a      = 1'b1;
          sel_a     = SelARs;
          sel_b     = (op == OpAddiu) ? SelBSext : SelBZext;
          dec_wreg  = 1'b1;
          dec_waddr = rt;
        end
        OpLui: begin
          alu       = AluOr;
          sel_b     = SelBLui;
          dec_wreg  = 1'b1;
          dec_waddr = rt;
        end
        OpLw: begin
          alu       = AluAddu;
          re_a      = 1'b1;
          sel_a     = SelARs;
          sel_b     = SelBSext;
          dec_wreg  = 1'b1;
          dec_waddr = rt;
          dec_load  = 1'b1;
        end
        OpSw: begin
          alu       = AluAddu;
          re_a      = 1'b1;
          re_b      = 1'b1;
          sel_a     = SelARs;
          sel_b     = SelBSext;
          dec_store = 1'b1;
        end
        default: ;
      endcase
    end
    if (dec_waddr == 5'd0) dec_wreg = 1'b0;
  end

  assign rf_reA   = re_a;
  assign rf_addrA = rs;
  assign rf_reB   = re_b;
  assign rf_addrB = rt;

  logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;

  assign hit_ex_a  = re_a && (rs != 5'd0) && ex_valid && ex_wreg && (ex_waddr == rs);
  assign hit_ex_b  = re_b && (rt != 5'd0) && ex_valid && ex_wreg && (ex_waddr == rt);
  assign hit_mem_a = re_a && (rs != 5'd0) && mem_wreg_i && (mem_waddr_i == rs);
  assign hit_mem_b = re_b && (rt != 5'd0) && mem_wreg_i && (mem_waddr_i == rt);

  logic [31:0] val_a, val_b;

`ifdef FORWARDING_EN
  always_comb begin
    val_a = hit_ex_a ? ex_result_i : (hit_mem_a ? mem_wdata_i : rf_dataA);
    val_b = hit_ex_b ? ex_result_i : (hit_mem_b ? mem_wdata_i : rf_dataB);
  end
  // Only a load in EX cannot be bypassed: its data does not exist yet.
  assign id_stall = ex_is_load & (hit_ex_a | hit_ex_b);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result_i, mem_wdata_i};
  assign val_a      = rf_dataA;
  assign val_b      = rf_dataB;
  assign id_stall   = hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b;
`endif

  logic [31:0] opa_d, opb_d;

  always_comb begin
    unique case (sel_a)
      SelARs:  opa_d = val_a;
      SelARt:  opa_d = val_b;
      default: opa_d = 32'd0;
    endcase
    unique case (sel_b)
      SelBRt:   opb_d = val_b;
      SelBSa:   opb_d = {27'd0, sa};
      SelBSext: opb_d = {{16{imm[15]}}, imm};
      SelBZext: opb_d = {16'd0, imm};
      SelBLui:  opb_d = {imm, 16'd0};
      default:  opb_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (!id_stall) begin
      id_valid_q <= if_valid;
      id_pc_q    <= if_pc;
      id_inst_q  <= if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || id_stall) begin
      ex_valid      <= 1'b0;
      ex_pc         <= 32'd0;
      ex_aluop      <= AluNop;
      ex_opa        <= 32'd0;
      ex_opb        <= 32'd0;
      ex_wreg       <= 1'b0;
      ex_waddr      <= 5'd0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
      ex_store_data <= 32'd0;
    end else begin
      ex_valid      <= id_valid_q;
      ex_pc         <= id_valid_q ? id_pc_q : 32'd0;
      ex_aluop      <= alu;
      ex_opa        <= opa_d;
      ex_opb        <= opb_d;
      ex_wreg       <= dec_wreg;
      ex_waddr      <= dec_waddr;
      ex_is_load    <= dec_load;
      ex_is_store   <= dec_store;
      ex_store_data <= dec_store ? val_b : 32'd0;
    end
  end

endmodule
